// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared field positions, state encoding and word masking for the sequencer
package seq_pkg;

  localparam int SEQ_IW   = 20;
  localparam int WE_B_BIT = 19;
  localparam int RS1_HI   = 18;
  localparam int RS1_LO   = 14;
  localparam int RS2_HI   = 13;
  localparam int RS2_LO   = 9;
  localparam int RD_HI    = 8;
  localparam int RD_LO    = 4;
  localparam int WE_A_BIT = 3;
  localparam int SEL_HI   = 2;
  localparam int SEL_LO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Non-issued words leave the bus all-zero so neither write-enable can fire.
  function automatic logic [SEQ_IW-1:0] mask_word(input logic [SEQ_IW-1:0] w, input logic v);
    logic [SEQ_IW-1:0] m;
    m = '0;
    if (v) begin
      m[WE_B_BIT]      = w[WE_B_BIT];
      m[RS1_HI:RS1_LO] = w[RS1_HI:RS1_LO];
      m[RS2_HI:RS2_LO] = w[RS2_HI:RS2_LO];
      m[RD_HI:RD_LO]   = w[RD_HI:RD_LO];
      m[WE_A_BIT]      = w[WE_A_BIT];
      m[SEL_HI:SEL_LO] = w[SEL_HI:SEL_LO];
    end
    return m;
  endfunction

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - DEPTH x IW program RAM, one write and one synchronous read port, write-first
module prog_mem #(
  parameter int IW    = 20,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  // rdata holds its value while re is low, which is how a stalled word is kept.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/instr_secuenciador.sv
// rtl/instr_secuenciador.sv - instruction sequencer: FSM, PC stepping and masked issue to the datapath
module instr_secuenciador
  import seq_pkg::*;
#(
  parameter int IW    = 20,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] last_addr,
  input  logic          start,
  input  logic          stall,
  output logic [IW-1:0] instruccion,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          prog_err
);

  seq_state_t    state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] last_q;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;
  logic          mem_we;
  logic          start_ok;

  assign mem_we   = prog_we && !busy;
  assign start_ok = start && !busy && ((state == ST_IDLE) || (state == ST_DONE));

  // fetch_pc names the word sitting in rd_data; the next word is prefetched as it issues.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = fetch_pc;
    case (state)
      ST_PRIME: rd_en = 1'b1;
      ST_RUN: begin
        if (!stall && (fetch_pc != last_q)) begin
          rd_en   = 1'b1;
          rd_addr = fetch_pc + 1'b1;
        end
      end
      default: rd_en = 1'b0;
    endcase
  end

  prog_mem #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      fetch_pc    <= '0;
      last_q      <= '0;
      pc          <= '0;
      instruccion <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      prog_err    <= 1'b0;
    end else begin
      prog_err    <= prog_we && busy;
      instr_valid <= 1'b0;
      instruccion <= mask_word(rd_data, 1'b0);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state    <= ST_PRIME;
            fetch_pc <= start_addr;
            last_q   <= last_addr;
            busy     <= 1'b1;
            done     <= 1'b0;
          end else if (state == ST_DONE) begin
            // Last word went out on the previous edge; the run is now over.
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        ST_PRIME: state <= ST_RUN;
        ST_RUN: begin
          if (!stall) begin
            instruccion <= mask_word(rd_data, 1'b1);
            instr_valid <= 1'b1;
            pc          <= fetch_pc;
            if (fetch_pc == last_q) state <= ST_DONE;
            else fetch_pc <= fetch_pc + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_secuenciador.sv
// tb/tb_instr_secuenciador.sv - directed self-checking bench for instr_secuenciador
module tb_instr_secuenciador;

  localparam int IW = 20;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] last_addr;
  logic          start;
  logic          stall;
  logic [IW-1:0] instruccion;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          prog_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] pcs[$];
  logic [IW-1:0] words[$];

  instr_secuenciador #(.IW(IW), .DEPTH(32), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start_addr  (start_addr),
    .last_addr   (last_addr),
    .start       (start),
    .stall       (stall),
    .instruccion (instruccion),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .prog_err    (prog_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  // Returns in cycle 0, i.e. just after the edge that accepted start.
  task automatic launch(input logic [AW-1:0] sa, input logic [AW-1:0] la);
    start_addr = sa;
    last_addr  = la;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [AW-1:0] p, input logic [IW-1:0] w);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check_eq({tag, "_pc"}, {27'd0, pc}, {27'd0, p});
    check_eq({tag, "_word"}, {12'd0, instruccion}, {12'd0, w});
  endtask

  task automatic collect(input int n);
    pcs.delete();
    words.delete();
    for (int i = 0; i < n; i++) begin
      step();
      if (instr_valid) begin
        pcs.push_back(pc);
        words.push_back(instruccion);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start_addr = '0; last_addr = '0; start = 1'b0; stall = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_instr", {12'd0, instruccion}, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_pc", {27'd0, pc}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, prog_err}, 32'd0);

    load(5'd0, 20'h8C0A9);
    load(5'd1, 20'h04125);
    load(5'd2, 20'h80008);
    load(5'd7, 20'h5A5A5);
    load(5'd30, 20'h12345);
    load(5'd31, 20'hABCDE);

    // Basic run: words in cycles 2..4, done from cycle 5.
    launch(5'd0, 5'd2);
    check_eq("t1_c0_busy", {31'd0, busy}, 32'd1);
    check_eq("t1_c0_valid", {31'd0, instr_valid}, 32'd0);
    step();
    check_eq("t1_c1_valid", {31'd0, instr_valid}, 32'd0);
    step(); expect_word("t1_c2", 5'd0, 20'h8C0A9);
    step(); expect_word("t1_c3", 5'd1, 20'h04125);
    step(); expect_word("t1_c4", 5'd2, 20'h80008);
    check_eq("t1_c4_done", {31'd0, done}, 32'd0);
    step();
    check_eq("t1_c5_done", {31'd0, done}, 32'd1);
    check_eq("t1_c5_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("t1_c5_busy", {31'd0, busy}, 32'd0);
    check_eq("t1_c5_instr", {12'd0, instruccion}, 32'd0);

    // Stall sampled on edges 3 and 4.
    launch(5'd0, 5'd2);
    check_eq("t2_c0_done_drop", {31'd0, done}, 32'd0);
    step();
    step(); expect_word("t2_c2", 5'd0, 20'h8C0A9);
    stall = 1'b1;
    step();
    check_eq("t2_c3_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("t2_c3_we", {30'd0, instruccion[19], instruccion[3]}, 32'd0);
    check_eq("t2_c3_instr", {12'd0, instruccion}, 32'd0);
    step();
    check_eq("t2_c4_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("t2_c4_we", {30'd0, instruccion[19], instruccion[3]}, 32'd0);
    stall = 1'b0;
    step(); expect_word("t2_c5", 5'd1, 20'h04125);
    step(); expect_word("t2_c6", 5'd2, 20'h80008);
    check_eq("t2_c6_done", {31'd0, done}, 32'd0);
    step();
    check_eq("t2_c7_done", {31'd0, done}, 32'd1);

    // Wrap-around 30 -> 1.
    launch(5'd30, 5'd1);
    collect(8);
    check_eq("t3_count", pcs.size(), 32'd4);
    check_eq("t3_pc0", {27'd0, pcs[0]}, 32'd30);
    check_eq("t3_pc1", {27'd0, pcs[1]}, 32'd31);
    check_eq("t3_pc2", {27'd0, pcs[2]}, 32'd0);
    check_eq("t3_pc3", {27'd0, pcs[3]}, 32'd1);
    check_eq("t3_w0", {12'd0, words[0]}, 32'h12345);
    check_eq("t3_w1", {12'd0, words[1]}, 32'hABCDE);
    check_eq("t3_w3", {12'd0, words[3]}, 32'h04125);
    check_eq("t3_done", {31'd0, done}, 32'd1);

    // Program write while busy is dropped and flagged.
    launch(5'd0, 5'd2);
    step();
    step();
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 20'hFFFFF;
    step();
    prog_we = 1'b0;
    check_eq("t4_err_pulse", {31'd0, prog_err}, 32'd1);
    step();
    check_eq("t4_err_clear", {31'd0, prog_err}, 32'd0);
    collect(4);
    check_eq("t4_done", {31'd0, done}, 32'd1);
    launch(5'd0, 5'd2);
    collect(6);
    check_eq("t4_rerun_count", pcs.size(), 32'd3);
    check_eq("t4_rerun_w1", {12'd0, words[1]}, 32'h04125);

    // Reset mid-run, then a clean rerun.
    launch(5'd0, 5'd2);
    step();
    step();
    step();
    check_eq("t5_pc1", {27'd0, pc}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5_instr", {12'd0, instruccion}, 32'd0);
    check_eq("t5_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("t5_pc", {27'd0, pc}, 32'd0);
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_done", {31'd0, done}, 32'd0);
    collect(3);
    check_eq("t5_no_issue", pcs.size(), 32'd0);
    launch(5'd0, 5'd2);
    collect(6);
    check_eq("t5_rerun_count", pcs.size(), 32'd3);
    check_eq("t5_rerun_w0", {12'd0, words[0]}, 32'h8C0A9);
    check_eq("t5_rerun_w2", {12'd0, words[2]}, 32'h80008);
    check_eq("t5_rerun_pc2", {27'd0, pcs[2]}, 32'd2);

    // Start while busy is ignored; single-word run.
    launch(5'd0, 5'd2);
    start_addr = 5'd7; last_addr = 5'd7; start = 1'b1;
    step();
    start = 1'b0;
    step(); expect_word("t6_c2", 5'd0, 20'h8C0A9);
    collect(6);
    check_eq("t6_rest_count", pcs.size(), 32'd2);
    check_eq("t6_rest_pc1", {27'd0, pcs[1]}, 32'd2);
    check_eq("t6_done", {31'd0, done}, 32'd1);
    launch(5'd7, 5'd7);
    collect(6);
    check_eq("t6_one_count", pcs.size(), 32'd1);
    check_eq("t6_one_pc", {27'd0, pcs[0]}, 32'd7);
    check_eq("t6_one_word", {12'd0, words[0]}, 32'h5A5A5);
    check_eq("t6_one_done", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
